// File: rtl/td_pkg.sv
// Shared types and helpers for the
// time-domain receiver blocks.
package td_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    HOLD
  } state_t;

  // Never returns less than 1, so a 1-state counter still gets a bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/td_rise_det.sv
// Registered rising-edge detector for an
// input already synchronous to clk.
module td_rise_det (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic in_q;

  always_ff @(posedge clk) begin
    if (rst) in_q <= 1'b0;
    else     in_q <= in;
  end

  assign rise = in & ~in_q;

endmodule

// File: rtl/td_count_tdc.sv
// Counter-based TDC: start-to-edge time,
// minus offset, quantised to T_UNIT cycles.
module td_count_tdc
  import td_pkg::*;
#(
  parameter int N_BIT  = 4,
  parameter int T_UNIT = 1,
  parameter int OFFSET = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in,
  output logic [N_BIT-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf,
  output logic             busy
);

  localparam int L  = OFFSET + T_UNIT * (2 ** N_BIT);
  localparam int EW = clog2(L + 1);
  localparam int PW = clog2(T_UNIT);

  localparam logic [N_BIT-1:0] FULL = '1;
  localparam logic [EW-1:0] E_LIM = EW'(L);
  localparam logic [EW-1:0] E_PRE =
    EW'((OFFSET > 0) ? OFFSET - 1 : 0);
  localparam logic [PW-1:0] PH_LAST = PW'(T_UNIT - 1);
  localparam logic PRE_SKIP = (OFFSET == 0);

  state_t             state;
  logic [EW-1:0]      e;
  logic               pre_done;
  logic [PW-1:0]      phase;
  logic [N_BIT-1:0]   code;
  logic               rise;

  td_rise_det u_rise (
    .clk  (clk),
    .rst  (rst),
    .in   (in),
    .rise (rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      e        <= '0;
      pre_done <= 1'b0;
      phase    <= '0;
      code     <= '0;
      out      <= '0;
      ovf      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= MEASURE;
            e        <= '0;
            pre_done <= PRE_SKIP;
            phase    <= '0;
            code     <= '0;
          end
        end
        MEASURE: begin
          e <= e + EW'(1);
          // code holds floor((e-OFFSET)/T_UNIT) for the current e
          if (!pre_done) begin
            if (e == E_PRE) pre_done <= 1'b1;
          end else if (phase == PH_LAST) begin
            phase <= '0;
            if (code != FULL) code <= code + N_BIT'(1);
          end else begin
            phase <= phase + PW'(1);
          end
          if (e == E_LIM) begin
            out   <= FULL;
            ovf   <= 1'b1;
            state <= HOLD;
          end else if (rise) begin
            out   <= code;
            ovf   <= 1'b0;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_td_count_tdc.sv
// Scoreboard bench for td_count_tdc: two
// instances (4/2/3 and 2/1/0).
module tb_td_count_tdc;

  typedef struct {
    int code;
    int ovf;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] st  = '0;
  logic [1:0] din = '0;
  logic [1:0] rdy = '1;
  logic [1:0] vld;
  logic [1:0] ovfs;
  logic [1:0] bsy;
  logic [3:0] out_a;
  logic [1:0] out_b;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [1:0] pv = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  td_count_tdc #(.N_BIT(4), .T_UNIT(2), .OFFSET(3)) dut (
    .clk(clk), .rst(rst), .start(st[0]), .in(din[0]),
    .out(out_a), .out_valid(vld[0]), .out_ready(rdy[0]),
    .ovf(ovfs[0]), .busy(bsy[0])
  );

  td_count_tdc #(.N_BIT(2), .T_UNIT(1), .OFFSET(0)) dut2 (
    .clk(clk), .rst(rst), .start(st[1]), .in(din[1]),
    .out(out_b), .out_valid(vld[1]), .out_ready(rdy[1]),
    .ovf(ovfs[1]), .busy(bsy[1])
  );

  task automatic check(input string name, input int act,
                       input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (vld[0] && !pv[0]) begin
      if (q0.size() == 0) begin
        check("a_unexpected_valid", 1, 0);
      end else begin
        x = q0.pop_front();
        check("a_out", int'(out_a), x.code);
        check("a_ovf", int'(ovfs[0]), x.ovf);
        check("a_valid_cycle", cyc, x.cyc);
      end
    end
    if (vld[1] && !pv[1]) begin
      if (q1.size() == 0) begin
        check("b_unexpected_valid", 1, 0);
      end else begin
        x = q1.pop_front();
        check("b_out", int'(out_b), x.code);
        check("b_ovf", int'(ovfs[1]), x.ovf);
        check("b_valid_cycle", cyc, x.cyc);
      end
    end
    pv = vld;
  end

  // er: rise at elapsed er; -1 none; -2 in already high
  task automatic frame_start(input int d, input int er,
                             input int code, input int ov);
    exp_t x;
    int c0;
    int lim;
    @(posedge clk); #1;
    c0 = cyc;
    st[d] = 1'b1;
    lim = (d == 0) ? 35 : 4;
    x.code = code;
    x.ovf  = ov;
    x.cyc  = c0 + 2 + ((er < 0) ? lim : er);
    if (d == 0) q0.push_back(x);
    else        q1.push_back(x);
    @(posedge clk); #1;
    st[d] = 1'b0;
    if (er >= 0) begin
      repeat (er) begin
        @(posedge clk); #1;
      end
      din[d] = 1'b1;
    end
  endtask

  task automatic wait_idle(input int d);
    for (int i = 0; i < 100; i++) begin
      if (!bsy[d]) break;
      @(posedge clk); #1;
    end
    check("frame_done", int'(bsy[d]), 0);
    din[d] = 1'b0;
  endtask

  task automatic run_frame(input int d, input int er,
                           input int code, input int ov);
    frame_start(d, er, code, ov);
    wait_idle(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset, then edges without start
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      din = {i[0], i[0]};
      @(posedge clk); #1;
      check("idle_valid", int'(vld), 0);
      check("idle_busy", int'(bsy), 0);
      check("idle_out", int'(out_a), 0);
      check("idle_ovf", int'(ovfs), 0);
    end
    din = '0;

    // quantisation sweep
    run_frame(0, 2, 0, 0);
    run_frame(0, 3, 0, 0);
    run_frame(0, 10, 3, 0);
    check("out_kept", int'(out_a), 3);
    check("ovf_kept", int'(ovfs[0]), 0);
    run_frame(0, 34, 15, 0);

    // timeout and rise exactly at the limit
    run_frame(0, -1, 15, 1);
    run_frame(0, 35, 15, 1);

    // backpressure; start and edges in HOLD ignored
    rdy[0] = 1'b0;
    frame_start(0, 10, 3, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", int'(vld[0]), 1);
      check("bp_out", int'(out_a), 3);
      st[0]  = (i == 1);
      din[0] = ~din[0];
      @(posedge clk); #1;
    end
    st[0]  = 1'b0;
    din[0] = 1'b0;
    check("bp_still_held", int'(vld[0]), 1);
    rdy[0] = 1'b1;
    @(posedge clk); #1;
    check("bp_release_busy", int'(bsy[0]), 0);
    check("bp_release_valid", int'(vld[0]), 0);
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_no_queued_start", int'(bsy[0]), 0);
    end

    // reset mid-measure at e=5
    @(posedge clk); #1;
    st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_busy", int'(bsy[0]), 0);
    check("rst_valid", int'(vld[0]), 0);
    check("rst_out", int'(out_a), 0);
    run_frame(0, 7, 2, 0);

    // second instance: T_UNIT=1, OFFSET=0, N_BIT=2
    for (int e = 0; e < 4; e++) run_frame(1, e, e, 0);
    din[1] = 1'b1;
    @(posedge clk); #1;
    frame_start(1, -2, 3, 1);
    wait_idle(1);

    repeat (4) @(posedge clk);
    #1;
    check("a_queue_drained", q0.size(), 0);
    check("b_queue_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/td_count_tdc.md
# td_count_tdc

Synchronous, counter-based time-to-digital receiver for the time-domain MAC datapath. It converts a time-encoded rising edge on `in`, produced upstream by the DTC/multiplier chain, into an N_BIT digital code. Elapsed time is measured in `clk` cycles from a frame `start` strobe, minus a calibration offset, and quantised in units of T_UNIT cycles. It is the digital read-out end of the chain and hands each result downstream over a valid/ready handshake.

## Interface
- N_BIT, 4: output code width; full-scale code is 2^N_BIT-1.
- T_UNIT, 1: clk cycles per LSB (>=1).
- OFFSET, 0: cycles of fixed path delay subtracted before quantisation (>=0).

- clk  in  1  sole clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  frame-start strobe; accepted only in IDLE.
- in  in  1  time-domain input, already synchronous to clk; the rising edge carries the value.
- out  out  N_BIT  measured code.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- ovf  out  1  set with the result when the window expired or the edge landed on the window limit.
- busy  out  1  high in MEASURE and HOLD.

## Operation
- States: IDLE, MEASURE, HOLD.
- IDLE: `start`=1 -> MEASURE, clear the elapsed counter e. `in` edges are ignored in IDLE.
- MEASURE:
  - e=0 in the first MEASURE cycle; e increments by 1 each cycle.
  - `in_q` is registered in every state; rise = in & ~in_q.
  - On rise at elapsed e: code = 0 if e<OFFSET, else min((e-OFFSET)/T_UNIT, 2^N_BIT-1) using floor division; ovf=0; -> HOLD.
  - Window limit L = OFFSET + T_UNIT*2^N_BIT. When e reaches L with no earlier rise: code = 2^N_BIT-1, ovf=1, -> HOLD. A rise exactly at e=L gives the same ovf result.
  - Division is not synthesised: use a phase counter (mod T_UNIT) after an OFFSET pre-count, plus a saturating code counter.
- HOLD:
  - out_valid=1; out and ovf are stable.
  - out_valid & out_ready -> IDLE, out_valid=0. out and ovf keep their last values until the next result.
- `start` in MEASURE or HOLD is ignored; it is neither queued nor restarts the measurement.
- If `in` is already high when `start` is accepted, no rise is seen, so the frame times out with ovf=1. Upstream must return `in` low between frames.
- busy = (state != IDLE).

## Timing
- Reset values: state=IDLE, out=0, out_valid=0, ovf=0, busy=0, in_q=0, counters=0.
- rst mid-MEASURE or mid-HOLD aborts immediately. The pending result is discarded and never presented.
- Latency: rise at MEASURE cycle e -> out_valid high on the next clk edge.
- start accepted at cycle 0 -> busy=1 from cycle 1. First MEASURE cycle (e=0) is cycle 1.
- Timeout: out_valid rises the cycle after e=L, i.e. L+2 cycles after start.
- Minimum frame: a handshake in the first HOLD cycle returns to IDLE. A new `start` can then be accepted in the following cycle, giving one idle cycle between frames.
- out_ready while out_valid=0 has no effect.

## Structure
- Package `td_pkg`:
  - state enum {IDLE, MEASURE, HOLD};
  - function clog2 for counter widths (e counter width = clog2(L+1)).
- Sub-module `td_rise_det`: in_q register plus rise output, reset by rst. It is reusable by other time-domain receivers.
- Everything else stays in one module: FSM, OFFSET pre-counter, T_UNIT phase counter, saturating code counter, output registers.

## Test plan
Defaults for scenarios 1-3 are N_BIT=4, T_UNIT=2, OFFSET=3, L=35.
1. Reset then idle: hold rst 2 cycles, toggle `in` without `start` -> out=0, out_valid=0, busy=0, ovf=0 throughout.
2. Quantisation sweep with out_ready=1:
   - rise at e=2 -> out=0;
   - e=3 -> 0;
   - e=10 -> 3;
   - e=34 -> 15, ovf=0;
   - in each case out_valid is seen one cycle after the rise.
3. Timeout/limit:
   - no rise -> out=15, ovf=1, out_valid at cycle 37 after start;
   - rise exactly at e=35 -> same result.
4. Backpressure:
   - out_ready=0 for 5 cycles -> out_valid stays 1 and out is stable;
   - a second `start` and extra `in` edges during HOLD are ignored;
   - out_ready=1 -> IDLE the next cycle.
5. Reset mid-MEASURE at e=5 -> next cycle IDLE, busy=0, out_valid never asserted. A following frame with rise at e=7 -> out=2.
6. T_UNIT=1, OFFSET=0, N_BIT=2 (L=4): rise at e=0..3 -> out=e; `in` high at start -> out=3, ovf=1.
